// File: rtl/mem_reg_write_buffer.sv
// In-order store FIFO feeding the memory register bank (addresses BASE_ADDR..TOP_ADDR),
// with youngest-first forwarding. Define MEM_REG_WB_COALESCE_EN to merge back-to-back stores to one address.
module mem_reg_write_buffer #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BASE_ADDR = 32,
    parameter int TOP_ADDR  = 63,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic              d,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              drain_en,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              addr_err,
    output logic              overflow,
    output logic              mem_reg_write,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              addr_err_q, overflow_q, mwr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic legal, full_w, empty_w, do_drain, do_enq, do_coal, drop;
    logic [PTR_W-1:0] fwd_idx;

    assign legal    = (push_addr >= ADDR_W'(BASE_ADDR)) && (push_addr <= ADDR_W'(TOP_ADDR));
    assign full_w   = (count_q == CNT_W'(DEPTH));
    assign empty_w  = (count_q == '0);
    assign do_drain = drain_en && !empty_w;

`ifdef MEM_REG_WB_COALESCE_EN
    logic [PTR_W-1:0] young;
    assign young   = tail_q - PTR_W'(1);
    // A draining single entry is already on its way out; a merge would be lost.
    assign do_coal = push && legal && !empty_w && valid_q[young] && (addr_q[young] == push_addr)
                     && !((count_q == CNT_W'(1)) && do_drain);
`else
    assign do_coal = 1'b0;
`endif

    // Full is judged before this edge's drain, so a push meeting a full buffer is always lost.
    assign do_enq = push && legal && !do_coal && !full_w;
    assign drop   = push && legal && !do_coal && full_w;

    always_ff @(posedge d or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            addr_err_q <= 1'b0;
            overflow_q <= 1'b0;
            mwr_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            addr_err_q <= push && !legal;
            if (drop) overflow_q <= 1'b1;
            mwr_q <= do_drain;
            if (do_drain) begin
                waddr_q         <= addr_q[head_q];
                wdata_q         <= data_q[head_q];
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (do_enq) begin
                addr_q[tail_q]  <= push_addr;
                data_q[tail_q]  <= push_data;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
`ifdef MEM_REG_WB_COALESCE_EN
            if (do_coal) data_q[young] <= push_data;
`endif
            count_q <= count_q + CNT_W'(do_enq) - CNT_W'(do_drain);
        end
    end

    // Walk oldest to youngest so the last match found is the newest store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign full          = full_w;
    assign empty         = empty_w;
    assign count         = count_q;
    assign addr_err      = addr_err_q;
    assign overflow      = overflow_q;
    assign mem_reg_write = mwr_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;

endmodule

// File: tb/tb_mem_reg_write_buffer.sv
// Directed bench for mem_reg_write_buffer: vector table plus reset and streaming sequences.
module tb_mem_reg_write_buffer;

    logic        d, reset, push, drain_en;
    logic [15:0] push_addr, push_data, fwd_addr;
    logic        full, empty, addr_err, overflow, mem_reg_write, fwd_hit;
    logic [2:0]  count;
    logic [15:0] write_address, write_data, fwd_data;

    int total = 0;
    int bad   = 0;

    mem_reg_write_buffer dut (
        .d(d), .reset(reset), .push(push), .push_addr(push_addr), .push_data(push_data),
        .drain_en(drain_en), .full(full), .empty(empty), .count(count), .addr_err(addr_err),
        .overflow(overflow), .mem_reg_write(mem_reg_write), .write_address(write_address),
        .write_data(write_data), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    initial d = 1'b0;
    always #5 d = ~d;

    typedef struct {
        logic        push;
        logic [15:0] pa, pd;
        logic        dr;
        logic [15:0] fa;
        logic [2:0]  cnt;
        logic        full, empty, mwr;
        logic [15:0] wa, wd;
        logic        aerr, ovf, hit;
        logic [15:0] fd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic p, logic [15:0] pa, logic [15:0] pd, logic dr, logic [15:0] fa,
                                logic [2:0] cnt, logic fu, logic em, logic mwr, logic [15:0] wa,
                                logic [15:0] wd, logic aerr, logic ovf, logic hit, logic [15:0] fd);
        vec_t v;
        v.push = p; v.pa = pa; v.pd = pd; v.dr = dr; v.fa = fa;
        v.cnt = cnt; v.full = fu; v.empty = em; v.mwr = mwr; v.wa = wa; v.wd = wd;
        v.aerr = aerr; v.ovf = ovf; v.hit = hit; v.fd = fd;
        return v;
    endfunction

    function automatic logic [63:0] obs();
        return {7'd0, count, full, empty, mem_reg_write, write_address, write_data,
                addr_err, overflow, fwd_hit, fwd_data};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        // {inputs} then {count full empty mwr waddr wdata addr_err overflow fwd_hit fwd_data}
        vecs.push_back(mk(1, 48, 23, 1, 48,  1, 0, 0, 0,  0,  0, 0, 0, 1, 23));
        vecs.push_back(mk(0,  0,  0, 1, 48,  0, 0, 1, 1, 48, 23, 0, 0, 0,  0));
        vecs.push_back(mk(0,  0,  0, 1, 48,  0, 0, 1, 0, 48, 23, 0, 0, 0,  0));
        vecs.push_back(mk(1, 40,  1, 0, 40,  1, 0, 0, 0, 48, 23, 0, 0, 1,  1));
        vecs.push_back(mk(1, 41,  2, 0, 40,  2, 0, 0, 0, 48, 23, 0, 0, 1,  1));
        vecs.push_back(mk(1, 42,  3, 0, 42,  3, 0, 0, 0, 48, 23, 0, 0, 1,  3));
        vecs.push_back(mk(1, 43,  4, 0, 43,  4, 1, 0, 0, 48, 23, 0, 0, 1,  4));
        vecs.push_back(mk(1, 44,  5, 0, 44,  4, 1, 0, 0, 48, 23, 0, 1, 0,  0));
        vecs.push_back(mk(0,  0,  0, 1, 40,  3, 0, 0, 1, 40,  1, 0, 1, 0,  0));
        vecs.push_back(mk(0,  0,  0, 1, 43,  2, 0, 0, 1, 41,  2, 0, 1, 1,  4));
        vecs.push_back(mk(0,  0,  0, 1, 43,  1, 0, 0, 1, 42,  3, 0, 1, 1,  4));
        vecs.push_back(mk(0,  0,  0, 1, 43,  0, 0, 1, 1, 43,  4, 0, 1, 0,  0));
        vecs.push_back(mk(0,  0,  0, 1,  0,  0, 0, 1, 0, 43,  4, 0, 1, 0,  0));
        vecs.push_back(mk(1, 31,  9, 1, 31,  0, 0, 1, 0, 43,  4, 1, 1, 0,  0));
        vecs.push_back(mk(1, 64,  9, 1, 64,  0, 0, 1, 0, 43,  4, 1, 1, 0,  0));
        vecs.push_back(mk(0,  0,  0, 1,  0,  0, 0, 1, 0, 43,  4, 0, 1, 0,  0));
        vecs.push_back(mk(1, 32,  7, 0, 32,  1, 0, 0, 0, 43,  4, 0, 1, 1,  7));
        vecs.push_back(mk(1, 63,  8, 0, 63,  2, 0, 0, 0, 43,  4, 0, 1, 1,  8));
        vecs.push_back(mk(0,  0,  0, 1, 63,  1, 0, 0, 1, 32,  7, 0, 1, 1,  8));
        vecs.push_back(mk(0,  0,  0, 1, 63,  0, 0, 1, 1, 63,  8, 0, 1, 0,  0));
        vecs.push_back(mk(1, 52, 27, 0, 52,  1, 0, 0, 0, 63,  8, 0, 1, 1, 27));
`ifdef MEM_REG_WB_COALESCE_EN
        vecs.push_back(mk(1, 52, 30, 0, 52,  1, 0, 0, 0, 63,  8, 0, 1, 1, 30));
        vecs.push_back(mk(0,  0,  0, 1, 52,  0, 0, 1, 1, 52, 30, 0, 1, 0,  0));
        vecs.push_back(mk(0,  0,  0, 1, 52,  0, 0, 1, 0, 52, 30, 0, 1, 0,  0));
`else
        vecs.push_back(mk(1, 52, 30, 0, 52,  2, 0, 0, 0, 63,  8, 0, 1, 1, 30));
        vecs.push_back(mk(0,  0,  0, 1, 52,  1, 0, 0, 1, 52, 27, 0, 1, 1, 30));
        vecs.push_back(mk(0,  0,  0, 1, 52,  0, 0, 1, 1, 52, 30, 0, 1, 0,  0));
`endif
        vecs.push_back(mk(1, 33,  1, 0, 33,  1, 0, 0, 0, 52, 30, 0, 1, 1,  1));
        vecs.push_back(mk(1, 34,  2, 0, 33,  2, 0, 0, 0, 52, 30, 0, 1, 1,  1));
        vecs.push_back(mk(1, 35,  3, 0, 35,  3, 0, 0, 0, 52, 30, 0, 1, 1,  3));
        vecs.push_back(mk(1, 36,  4, 0, 36,  4, 1, 0, 0, 52, 30, 0, 1, 1,  4));
        // Push while full plus drain on the same edge: the push is lost.
        vecs.push_back(mk(1, 37,  5, 1, 37,  3, 0, 0, 1, 33,  1, 0, 1, 0,  0));

        reset = 1'b0; push = 1'b0; push_addr = '0; push_data = '0; drain_en = 1'b0; fwd_addr = '0;
        repeat (2) @(posedge d);
        #1 chk("reset_state", obs(), {7'd0, 3'd0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0});
        @(negedge d) reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge d);
            push = vecs[i].push; push_addr = vecs[i].pa; push_data = vecs[i].pd;
            drain_en = vecs[i].dr; fwd_addr = vecs[i].fa;
            @(posedge d);
            #1 chk($sformatf("vec%0d", i), obs(),
                   {7'd0, vecs[i].cnt, vecs[i].full, vecs[i].empty, vecs[i].mwr, vecs[i].wa, vecs[i].wd,
                    vecs[i].aerr, vecs[i].ovf, vecs[i].hit, vecs[i].fd});
        end

        // Asynchronous reset between edges with three entries pending.
        @(negedge d);
        push = 1'b0; drain_en = 1'b1; reset = 1'b0;
        #1 chk("async_reset", {60'd0, count, 1'b0} | {63'd0, mem_reg_write | overflow | !empty}, 64'd0);
        @(posedge d);
        @(negedge d) reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge d);
            #1 chk($sformatf("post_reset%0d", k), {59'd0, count, mem_reg_write, empty}, {59'd0, 3'd0, 1'b0, 1'b1});
        end

        // Streaming push+drain every edge: output trails input by one cycle.
        for (int k = 0; k < 10; k++) begin
            @(negedge d);
            push = 1'b1; push_addr = 16'(32 + k); push_data = 16'(100 + k); drain_en = 1'b1;
            @(posedge d);
            if (k == 0)
                #1 chk("stream0", {60'd0, count, mem_reg_write}, {60'd0, 3'd1, 1'b0});
            else
                #1 chk($sformatf("stream%0d", k), {28'd0, count, mem_reg_write, write_address, write_data},
                       {28'd0, 3'd1, 1'b1, 16'(32 + k - 1), 16'(100 + k - 1)});
        end
        @(negedge d) push = 1'b0;
        @(posedge d);
        #1 chk("stream_tail", {28'd0, count, mem_reg_write, write_address, write_data},
               {28'd0, 3'd0, 1'b1, 16'd41, 16'd109});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
